// File: rtl/wimax_bist_ctrl_pkg.sv
// Shared types and default timing for the WiMAX PHY self-test controller.
// Default RUN length is the 25 us observation window expressed in 50 MHz clocks.
package Package_wimax;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_LOCK,
    ST_LOAD,
    ST_SETTLE,
    ST_RUN,
    ST_DONE
  } bist_state_t;

  localparam int unsigned CLK_50_PERIOD     = 20;     // ns
  localparam int unsigned RUN_WINDOW_NS     = 25000;
  localparam int unsigned DEF_N_STAGES      = 4;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 1000;
  localparam int unsigned DEF_LOAD_CYCLES   = 1;
  localparam int unsigned DEF_SETTLE_CYCLES = 10;
  localparam int unsigned DEF_RUN_CYCLES    = RUN_WINDOW_NS / CLK_50_PERIOD;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/wimax_bist_ctrl_timer.sv
// Down-counter shared by all timed BIST states: reload on start, expire while
// the count sits at 1, so a load value of N spans exactly N cycles.
module wimax_bist_timer #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk_ref,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  output logic             expire
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_ref or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/wimax_bist_ctrl.sv
// Self-test sequencer for the WiMAX PHY chain: wait for PLL lock, seed-load,
// settle, run, then latch a per-stage verdict until the next start.
module wimax_bist_ctrl
  import Package_wimax::*;
#(
  parameter int unsigned N_STAGES      = DEF_N_STAGES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned LOAD_CYCLES   = DEF_LOAD_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned RUN_CYCLES    = DEF_RUN_CYCLES
) (
  input  logic                clk_ref,
  input  logic                reset,
  input  logic                start,
  input  logic                pll_locked,
  input  logic [N_STAGES-1:0] stage_pass,
  output logic                load,
  output logic                en,
  output logic                busy,
  output logic                done,
  output logic                pass_all,
  output logic [N_STAGES-1:0] fail_mask,
  output logic                lock_err
);

  localparam int unsigned T_MAX = max4(LOCK_TIMEOUT, LOAD_CYCLES, SETTLE_CYCLES, RUN_CYCLES);
  localparam int unsigned TMR_W = $clog2(T_MAX) + 1;

  bist_state_t state_q, state_d;

  logic                load_q,     load_d;
  logic                en_q,       en_d;
  logic                busy_q,     busy_d;
  logic                done_q,     done_d;
  logic                pass_all_q, pass_all_d;
  logic                lock_err_q, lock_err_d;
  logic [N_STAGES-1:0] fail_mask_q, fail_mask_d;
  logic [N_STAGES-1:0] seen_q,      seen_d;
  logic [N_STAGES-1:0] dropped_q,   dropped_d;

  logic             tmr_start;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_expire;

  wimax_bist_timer #(
    .WIDTH(TMR_W)
  ) u_timer (
    .clk_ref  (clk_ref),
    .reset    (reset),
    .start    (tmr_start),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  always_comb begin : next_state
    state_d     = state_q;
    fail_mask_d = fail_mask_q;
    lock_err_d  = lock_err_q;
    seen_d      = seen_q;
    dropped_d   = dropped_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_WAIT_LOCK;
          fail_mask_d = '0;
          lock_err_d  = 1'b0;
          seen_d      = '0;
          dropped_d   = '0;
        end
      end

      ST_WAIT_LOCK: begin
        if (pll_locked) begin
          state_d = ST_LOAD;
        end else if (tmr_expire) begin
          state_d     = ST_DONE;
          lock_err_d  = 1'b1;
          fail_mask_d = '1;
        end
      end

      ST_LOAD, ST_SETTLE, ST_RUN: begin
        if (state_q == ST_RUN) begin
          seen_d    = seen_q | stage_pass;
          dropped_d = dropped_q | (seen_q & ~stage_pass);
        end
        // Lock loss is tested before expiry so it wins on the last RUN cycle.
        if (!pll_locked) begin
          state_d     = ST_DONE;
          lock_err_d  = 1'b1;
          fail_mask_d = '1;
        end else if (tmr_expire) begin
          if (state_q == ST_LOAD) begin
            state_d = ST_SETTLE;
          end else if (state_q == ST_SETTLE) begin
            state_d = ST_RUN;
          end else begin
            state_d     = ST_DONE;
            lock_err_d  = 1'b0;
            fail_mask_d = ~seen_q | dropped_q | ~stage_pass;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin : timer_ctl
    tmr_start = 1'b0;
    tmr_val   = '0;
    if (state_d != state_q) begin
      case (state_d)
        ST_WAIT_LOCK: begin tmr_start = 1'b1; tmr_val = TMR_W'(LOCK_TIMEOUT);  end
        ST_LOAD:      begin tmr_start = 1'b1; tmr_val = TMR_W'(LOAD_CYCLES);   end
        ST_SETTLE:    begin tmr_start = 1'b1; tmr_val = TMR_W'(SETTLE_CYCLES); end
        ST_RUN:       begin tmr_start = 1'b1; tmr_val = TMR_W'(RUN_CYCLES);    end
        default:      ;
      endcase
    end
  end

  // Outputs are decoded from the next state so the registers line up with state_q.
  always_comb begin : out_decode
    load_d     = (state_d == ST_LOAD);
    en_d       = (state_d == ST_RUN);
    busy_d     = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d     = (state_d == ST_DONE);
    pass_all_d = (state_d == ST_DONE) && (fail_mask_d == '0) && !lock_err_d;
  end

  always_ff @(posedge clk_ref or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      load_q      <= 1'b0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_all_q  <= 1'b0;
      lock_err_q  <= 1'b0;
      fail_mask_q <= '0;
      seen_q      <= '0;
      dropped_q   <= '0;
    end else begin
      state_q     <= state_d;
      load_q      <= load_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_all_q  <= pass_all_d;
      lock_err_q  <= lock_err_d;
      fail_mask_q <= fail_mask_d;
      seen_q      <= seen_d;
      dropped_q   <= dropped_d;
    end
  end

  assign load      = load_q;
  assign en        = en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass_all  = pass_all_q;
  assign lock_err  = lock_err_q;
  assign fail_mask = fail_mask_q;

endmodule
